mem_resp_queue: RTL
===================

Name: mem_resp_queue

Overview:
- Parametrised in-order memory-response queue for the MEM stage.
- Tracks up to DEPTH outstanding load/store accesses issued to the dcache. Captures data_ok responses in order and holds them while writeback stalls.
- Performs load byte/half/word/dword alignment and sign/zero extension, then presents retired accesses to WB.
- On pipeline flush, discards all entries and silently drains responses still in flight.

Parameters:
DATA_W, 32, memory data width; legal values 32 or 64
DEPTH, 4, queue entries and maximum outstanding responses; power of 2, >=2
OFS_W, $clog2(DATA_W/8), address-offset width (derived, do not override)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline flush (excp/ertn/refetch/icacop/idle OR)
req_valid  in  1  access issued to dcache this cycle
req_ready  out  1  queue can accept an access
req_load  in  1  1=load, 0=store
req_size  in  2  0=byte,1=half,2=word,3=dword (DATA_W=64 only)
req_sign  in  1  sign-extend load result
req_ofs  in  OFS_W  low address bits
req_dest  in  5  destination GPR
req_nores  in  1  access cancelled (exception); no memory response will come
resp_valid  in  1  dcache data_ok
resp_data  in  DATA_W  dcache read data
out_valid  out  1  head entry complete
out_ready  in  1  WB allowin
out_load  out  1  head is a load
out_wen  out  1  out_load && dest!=0 && !nores
out_dest  out  5  head destination
out_data  out  DATA_W  aligned/extended load data; 0 for stores/nores
pending  out  $clog2(DEPTH+1)  live entry count
drop_cnt  out  $clog2(DEPTH+1)  flushed responses still to discard
proto_err  out  1  sticky: unexpected response seen

Behaviour:
- Reset: all entries invalid; pending=0; drop_cnt=0; proto_err=0; out_valid=0; req_ready=1; head, response and tail pointers = 0.
- Entry fields: load, size, sign, ofs, dest, nores, done, data.
- Enqueue on req_valid && req_ready. Entry written at tail; done = req_nores.
- req_ready = !flush && (pending + drop_cnt) < DEPTH. Total memory-outstanding responses never exceed DEPTH.
- Response routing:
  - drop_cnt != 0: the response is discarded and drop_cnt decrements.
  - Otherwise: data is written to the oldest entry with done=0 (response pointer skips nores entries), and that entry's done is set.
  - No such entry: response ignored, proto_err set (sticky until reset).
- A response written in cycle N gives out_valid at the head in cycle N+1 (registered; no combinational bypass).
- An entry enqueued in cycle N with req_nores=1 is visible at the head in N+1.
- out_valid = head valid && head done && !flush. Dequeue on out_valid && out_ready. Enqueue and dequeue in the same cycle: pending unchanged.
- Load extraction:
  - Shift = ofs*8; take 8/16/32/64 bits per size.
  - Sign/zero extend to DATA_W per sign.
  - Misalignment is not checked (ALE is raised upstream).
  - size=3 with DATA_W=32 is treated as word.
- Flush (takes priority over every other event in the same cycle):
  - All entries are invalidated; pointers and pending reset to 0.
  - drop_cnt_next = drop_cnt + (#entries with !done && !nores) − (resp_valid ? 1 : 0).
  - A resp_valid in the flush cycle is discarded.
  - req in the flush cycle is not accepted (req_ready=0).
  - The output handshake in the flush cycle is void (out_valid=0).
- Wrap-around: pointers are modulo DEPTH. Full = (pending==DEPTH).
- reset during drain clears drop_cnt; memory is reset alongside.

Test Plan:
- DATA_W=32, load word ofs=0, resp 0x8899AABB one cycle later, out_ready=1 -> out_valid in the cycle after resp; out_data=0x8899AABB; out_wen=1.
- Load byte signed ofs=3 with resp 0x80FF0000 -> out_data=0xFFFFFF80. Unsigned half ofs=2 -> 0x000080FF. DATA_W=64 dword ofs=0 passes the 64-bit value through.
- Fill 4 loads with out_ready=0 -> req_ready=0 at pending=4. Return 4 responses, then release out_ready -> 4 retirements in order over 4 cycles; pointers wrap; pending=0.
- 3 loads outstanding (1 done), flush asserted with coincident resp_valid -> drop_cnt=1. Next resp is discarded. The following new load gets the subsequent response.
- Store with req_nores=1 between two loads -> retires without a response, out_data=0, out_wen=0. Response order is still assigned to the loads.
- resp_valid with queue empty and drop_cnt=0 -> proto_err=1 and remains set; state otherwise unchanged.

Source files
------------

// File: rtl/mem_resp_queue.sv
// In-order MEM-stage response queue: tracks outstanding dcache accesses, captures
// data_ok responses in issue order, aligns/extends load data and retires entries to WB.
module mem_resp_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OFS_W  = $clog2(DATA_W/8)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_load,
  input  logic [1:0]                 req_size,
  input  logic                       req_sign,
  input  logic [OFS_W-1:0]           req_ofs,
  input  logic [4:0]                 req_dest,
  input  logic                       req_nores,
  input  logic                       resp_valid,
  input  logic [DATA_W-1:0]          resp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_load,
  output logic                       out_wen,
  output logic [4:0]                 out_dest,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [$clog2(DEPTH+1)-1:0] drop_cnt,
  output logic                       proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = CNT_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  pend_q, pend_d, drop_q, drop_d;
  logic              perr_q, perr_d;
  logic [DEPTH-1:0]  load_q, load_d, sign_q, sign_d, nores_q, nores_d, done_q, done_d;
  logic [1:0]        size_q [DEPTH];
  logic [1:0]        size_d [DEPTH];
  logic [OFS_W-1:0]  ofs_q  [DEPTH];
  logic [OFS_W-1:0]  ofs_d  [DEPTH];
  logic [4:0]        dest_q [DEPTH];
  logic [4:0]        dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic              found, enq, deq;
  logic [PTR_W-1:0]  idx, ridx;
  logic [CNT_W-1:0]  inflight;
  logic [SUM_W-1:0]  drop_sum;

  // Shift the addressed lane down, then sign/zero extend above the access width.
  function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] raw,
                                                   input logic [OFS_W-1:0]  ofs,
                                                   input logic [1:0]        size,
                                                   input logic              sgn);
    logic [DATA_W-1:0] sh, res;
    logic              msb;
    int                nbits;
    sh = raw >> {ofs, 3'b000};
    case (size)
      2'd0:    begin nbits = 8;  msb = sh[7];  end
      2'd1:    begin nbits = 16; msb = sh[15]; end
      2'd2:    begin nbits = 32; msb = sh[31]; end
      default: begin
        nbits = (DATA_W == 64) ? 64 : 32;
        msb   = (DATA_W == 64) ? sh[DATA_W-1] : sh[31];
      end
    endcase
    res = sh;
    for (int b = 0; b < DATA_W; b++) begin
      if (b >= nbits) res[b] = sgn & msb;
    end
    return res;
  endfunction

  assign req_ready = !flush && ((SUM_W'(pend_q) + SUM_W'(drop_q)) < SUM_W'(DEPTH));
  assign out_valid = (pend_q != '0) && done_q[head_q] && !flush;
  assign out_load  = load_q[head_q];
  assign out_dest  = dest_q[head_q];
  assign out_wen   = load_q[head_q] && (dest_q[head_q] != 5'd0) && !nores_q[head_q];
  assign out_data  = (load_q[head_q] && !nores_q[head_q])
                   ? align_load(data_q[head_q], ofs_q[head_q], size_q[head_q], sign_q[head_q])
                   : '0;
  assign pending   = pend_q;
  assign drop_cnt  = drop_q;
  assign proto_err = perr_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    perr_d   = perr_q;
    load_d   = load_q;
    sign_d   = sign_q;
    nores_d  = nores_q;
    done_d   = done_q;
    size_d   = size_q;
    ofs_d    = ofs_q;
    dest_d   = dest_q;
    data_d   = data_q;
    found    = 1'b0;
    idx      = head_q;
    ridx     = head_q;
    inflight = '0;
    drop_sum = '0;
    enq      = req_valid && req_ready;
    deq      = out_valid && out_ready;

    // Oldest live entry still waiting on memory; nores entries are born done and skipped.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < pend_q) && !done_q[idx]) begin
        inflight = inflight + CNT_W'(1);
        if (!found) begin
          found = 1'b1;
          ridx  = idx;
        end
      end
    end

    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      pend_d   = '0;
      done_d   = '0;
      drop_sum = SUM_W'(drop_q) + SUM_W'(inflight);
      if (resp_valid) begin
        if (drop_sum != '0) drop_sum = drop_sum - SUM_W'(1);
        else                perr_d   = 1'b1;
      end
      drop_d = CNT_W'(drop_sum);
    end else begin
      if (resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else if (found) begin
          data_d[ridx] = resp_data;
          done_d[ridx] = 1'b1;
        end else begin
          perr_d = 1'b1;
        end
      end
      if (enq) begin
        load_d[tail_q]  = req_load;
        sign_d[tail_q]  = req_sign;
        nores_d[tail_q] = req_nores;
        done_d[tail_q]  = req_nores;
        size_d[tail_q]  = req_size;
        ofs_d[tail_q]   = req_ofs;
        dest_d[tail_q]  = req_dest;
        data_d[tail_q]  = '0;
        tail_d          = tail_q + PTR_W'(1);
      end
      if (deq) head_d = head_q + PTR_W'(1);
      pend_d = pend_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      perr_q  <= 1'b0;
      load_q  <= '0;
      sign_q  <= '0;
      nores_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        size_q[i] <= '0;
        ofs_q[i]  <= '0;
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      perr_q  <= perr_d;
      load_q  <= load_d;
      sign_q  <= sign_d;
      nores_q <= nores_d;
      done_q  <= done_d;
      size_q  <= size_d;
      ofs_q   <= ofs_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

endmodule
